// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } resp_state_t;

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port request/response sequencer: accepts one request, waits LATENCY
// cycles, then pulses rvalid for one cycle with the registered read word.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready=1, request accepted at the next edge if req=1
// S_WAIT | wait-state countdown, new requests ignored
// S_RESP | rvalid=1 for one cycle, rdata holds the captured word
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            cap_en,
  input  logic [XLEN-1:0] rd_word,
  output logic            ready,
  output logic            accept,
  output logic            rvalid,
  output logic [XLEN-1:0] rdata
);

  // LATENCY=0 skips S_WAIT entirely, so the load value is irrelevant there.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  resp_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [XLEN-1:0]  rdata_q;

  assign accept = req & ready;
  assign rdata  = rdata_q;

  // State, wait counter and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept && cap_en) rdata_q <= rd_word;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    rvalid    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_RESP: begin
        rvalid    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Shared word-addressed storage behind independent fetch and data ports,
// each with a fixed wait-state latency.
// Optional macro MEM_RESP_ERR_EN adds i_err/d_err for out-of-range or
// misaligned addresses; without it the address wraps modulo the depth.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 14,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  output logic            d_ready,
  input  logic            d_wen,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata
`ifdef MEM_RESP_ERR_EN
  ,
  output logic            i_err,
  output logic            d_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [XLEN-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic [XLEN-1:0]       i_word, d_word;
  logic                  i_accept, d_accept, d_we;

  assign i_idx = i_addr[DEPTH_LOG2+1:2];
  assign d_idx = d_addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_ERR_EN
  logic i_bad, d_bad, i_err_q, d_err_q;

  assign i_bad  = (|i_addr[XLEN-1:DEPTH_LOG2+2]) | (|i_addr[1:0]);
  assign d_bad  = (|d_addr[XLEN-1:DEPTH_LOG2+2]) | (|d_addr[1:0]);
  assign i_word = i_bad ? '0 : mem[i_idx];
  assign d_word = d_bad ? '0 : mem[d_idx];
  assign d_we   = d_accept & d_wen & ~d_bad;
  assign i_err  = i_rvalid & i_err_q;
  assign d_err  = d_rvalid & d_err_q;

  // Error flags captured with the request, shown only with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      if (i_accept) i_err_q <= i_bad;
      if (d_accept) d_err_q <= d_bad;
    end
  end
`else
  logic unused_addr_bits;

  assign i_word = mem[i_idx];
  assign d_word = mem[d_idx];
  assign d_we   = d_accept & d_wen;
  assign unused_addr_bits = ^{i_addr[XLEN-1:DEPTH_LOG2+2], i_addr[1:0],
                              d_addr[XLEN-1:DEPTH_LOG2+2], d_addr[1:0]};
`endif

  // Write commit at the acceptance edge; a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (d_we) mem[d_idx] <= d_wdata;
  end

  mem_port_fsm #(.LATENCY(LATENCY)) u_fetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (i_req),
    .cap_en  (1'b1),
    .rd_word (i_word),
    .ready   (i_ready),
    .accept  (i_accept),
    .rvalid  (i_rvalid),
    .rdata   (i_rdata)
  );

  // Writes leave the data response register untouched.
  mem_port_fsm #(.LATENCY(LATENCY)) u_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (d_req),
    .cap_en  (~d_wen),
    .rd_word (d_word),
    .ready   (d_ready),
    .accept  (d_accept),
    .rvalid  (d_rvalid),
    .rdata   (d_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 0, 1, 3)
// share the same request stimulus; expected responses are queued per
// instance and port when issued and popped by a negedge monitor.
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic [2:0]        i_ready_a, i_rvalid_a, d_ready_a, d_rvalid_a;
  logic [2:0][31:0]  i_rdata_a, d_rdata_a;
  logic [2:0]        i_err_a, d_err_a;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [31:0] d_last = '0;

  exp_t iq [3][$];
  exp_t dq [3][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int lat(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  mem_responder #(.DEPTH_LOG2(14), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_ready(i_ready_a[0]), .i_addr(i_addr),
    .i_rvalid(i_rvalid_a[0]), .i_rdata(i_rdata_a[0]),
    .d_req(d_req), .d_ready(d_ready_a[0]), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid_a[0]), .d_rdata(d_rdata_a[0])
`ifdef MEM_RESP_ERR_EN
    , .i_err(i_err_a[0]), .d_err(d_err_a[0])
`endif
  );

  mem_responder #(.DEPTH_LOG2(14), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_ready(i_ready_a[1]), .i_addr(i_addr),
    .i_rvalid(i_rvalid_a[1]), .i_rdata(i_rdata_a[1]),
    .d_req(d_req), .d_ready(d_ready_a[1]), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid_a[1]), .d_rdata(d_rdata_a[1])
`ifdef MEM_RESP_ERR_EN
    , .i_err(i_err_a[1]), .d_err(d_err_a[1])
`endif
  );

  mem_responder #(.DEPTH_LOG2(14), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_ready(i_ready_a[2]), .i_addr(i_addr),
    .i_rvalid(i_rvalid_a[2]), .i_rdata(i_rdata_a[2]),
    .d_req(d_req), .d_ready(d_ready_a[2]), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid_a[2]), .d_rdata(d_rdata_a[2])
`ifdef MEM_RESP_ERR_EN
    , .i_err(i_err_a[2]), .d_err(d_err_a[2])
`endif
  );

`ifndef MEM_RESP_ERR_EN
  assign i_err_a = '0;
  assign d_err_a = '0;
`endif

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d (lat %0d): got %h expected %h at cycle %0d",
               name, k, lat(k), act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (i_rvalid_a[k] === 1'b1) begin
        if (iq[k].size() == 0) chk("i_unexpected_rvalid", k, 32'd1, 32'd0);
        else begin
          mon_e = iq[k].pop_front();
          chk("i_rdata", k, i_rdata_a[k], mon_e.data);
          chk("i_latency_cycle", k, cyc, mon_e.cyc);
`ifdef MEM_RESP_ERR_EN
          chk("i_err", k, {31'b0, i_err_a[k]}, {31'b0, mon_e.err});
`endif
        end
      end
      if (d_rvalid_a[k] === 1'b1) begin
        if (dq[k].size() == 0) chk("d_unexpected_rvalid", k, 32'd1, 32'd0);
        else begin
          mon_e = dq[k].pop_front();
          chk("d_rdata", k, d_rdata_a[k], mon_e.data);
          chk("d_latency_cycle", k, cyc, mon_e.cyc);
`ifdef MEM_RESP_ERR_EN
          chk("d_err", k, {31'b0, d_err_a[k]}, {31'b0, mon_e.err});
`endif
        end
      end
    end
  end

  task automatic rst_chk(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_i_ready"},  k, {31'b0, i_ready_a[k]},  32'd1);
      chk({tag, "_d_ready"},  k, {31'b0, d_ready_a[k]},  32'd1);
      chk({tag, "_i_rvalid"}, k, {31'b0, i_rvalid_a[k]}, 32'd0);
      chk({tag, "_d_rvalid"}, k, {31'b0, d_rvalid_a[k]}, 32'd0);
      chk({tag, "_i_rdata"},  k, i_rdata_a[k], 32'd0);
      chk({tag, "_d_rdata"},  k, d_rdata_a[k], 32'd0);
`ifdef MEM_RESP_ERR_EN
      chk({tag, "_i_err"}, k, {31'b0, i_err_a[k]}, 32'd0);
      chk({tag, "_d_err"}, k, {31'b0, d_err_a[k]}, 32'd0);
`endif
    end
  endtask

  // Issue one request per selected port (all instances idle), hold req for
  // 'hold' edges, queue expectations and check the ready profile.
  task automatic issue(input bit do_i, input logic [31:0] ia, input logic [31:0] iexp,
                       input bit ierr, input bit do_d, input bit wen,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [31:0] rexp, input bit derr, input int hold);
    logic [31:0] dexp;
    bit          exp_rdy;
    @(negedge clk);
    dexp = wen ? d_last : rexp;
    if (do_d && !wen) d_last = rexp;
    i_req = do_i; i_addr = ia;
    d_req = do_d; d_wen = wen; d_addr = da; d_wdata = wd;
    for (int k = 0; k < 3; k++) begin
      if (do_i) iq[k].push_back('{iexp, cyc + 1 + lat(k), ierr});
      if (do_d) dq[k].push_back('{dexp, cyc + 1 + lat(k), derr});
    end
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j == hold - 1) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_rdy = (j >= lat(k) + 1);
        if (do_i) chk("i_ready_profile", k, {31'b0, i_ready_a[k]}, {31'b0, exp_rdy});
        if (do_d) chk("d_ready_profile", k, {31'b0, d_ready_a[k]}, {31'b0, exp_rdy});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Preload program words, then fetch them.
    issue(0, 0, 0, 0, 1, 1, 32'h0000_0000, 32'h0000_0513, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 1, 32'h0000_0004, 32'h0010_0593, 0, 0, 1);
    issue(1, 32'h0000_0000, 32'h0000_0513, 0, 0, 0, 0, 0, 0, 0, 1);
    issue(1, 32'h0000_0004, 32'h0010_0593, 0, 0, 0, 0, 0, 0, 0, 1);

    // Data write, read back, then a write whose ack must keep the old rdata.
    issue(0, 0, 0, 0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 1);
    issue(0, 0, 0, 0, 1, 1, 32'h0000_0104, 32'h1234_5678, 0, 0, 1);

    // Same-edge fetch and write to one word: fetch sees the old value.
    issue(0, 0, 0, 0, 1, 1, 32'h0000_0040, 32'h1111_1111, 0, 0, 1);
    issue(1, 32'h0000_0040, 32'h1111_1111, 0, 1, 1, 32'h0000_0040, 32'h2222_2222, 0, 0, 1);
    issue(1, 32'h0000_0040, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 1);

    // Requests held into the busy window must produce a single response.
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0104, 0, 32'h1234_5678, 0, 2);
    issue(1, 32'h0000_0004, 32'h0010_0593, 0, 0, 0, 0, 0, 0, 0, 2);

`ifdef MEM_RESP_ERR_EN
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0102, 0, 32'h0000_0000, 1, 1);
    issue(0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'h5555_5555, 0, 1, 1);
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0513, 0, 1);
    issue(1, 32'h0000_0006, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0, 1);
`else
    issue(1, 32'h0000_0006, 32'h0010_0593, 0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'hCAFE_F00D, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 32'hCAFE_F00D, 0, 1);
`endif

    // Reset while a read is outstanding: drop it, outputs clear at once.
    @(negedge clk);
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0100;
    @(posedge clk);
    #1 d_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_chk("async_reset");
    d_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Storage survives reset.
    issue(0, 0, 0, 0, 1, 0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 1);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("i_missing_responses", k, iq[k].size(), 32'd0);
      chk("d_missing_responses", k, dq[k].size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
